// File: rtl/counter_b32_ctrl_if.sv
// Command/status and counter_b32 side-band bundle for counter_b32_ctrl.
// master = command source plus counter_b32 returns; slave = the controller.
interface counter_b32_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_preload;
  logic [1:0]       cmd_mode;
  logic [31:0]      cmd_D;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;

  logic             ctr_enable;
  logic [1:0]       ctr_mode;
  logic [31:0]      ctr_D;
  logic [7:0]       ctr_load;
  logic [7:0]       ctr_rco;
  logic [31:0]      ctr_Q;

  logic             busy;
  logic             done;
  logic             aborted;
  logic             load_err;
  logic [CNT_W-1:0] rco_count;
  logic [31:0]      final_Q;

  modport master (
    output cmd_valid, cmd_preload, cmd_mode, cmd_D, cmd_len, abort,
    output ctr_load, ctr_rco, ctr_Q,
    input  cmd_ready, ctr_enable, ctr_mode, ctr_D,
    input  busy, done, aborted, load_err, rco_count, final_Q
  );

  modport slave (
    input  cmd_valid, cmd_preload, cmd_mode, cmd_D, cmd_len, abort,
    input  ctr_load, ctr_rco, ctr_Q,
    output cmd_ready, ctr_enable, ctr_mode, ctr_D,
    output busy, done, aborted, load_err, rco_count, final_Q
  );
endinterface

// File: rtl/counter_b32_ctrl.sv
// Command sequencer for counter_b32: optional preload+check, timed run, carry counting.
// Optional macro CTRL_RCO_ANY_EN: any nibble carry (|ctr_rco) counts instead of ctr_rco[7] only.
module counter_b32_ctrl #(
  parameter int         CNT_W     = 16,
  parameter logic [1:0] MODE_LOAD = 2'b11
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset,
  counter_b32_ctrl_if.slave ctrl
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic [31:0]      r_D;
  logic [CNT_W-1:0] r_remain;
  logic             r_prev_run;
  logic             r_aborted;
  logic             r_load_err;
  logic [CNT_W-1:0] r_rco_count;
  logic [31:0]      r_final_Q;

  logic             w_accept;
  logic [CNT_W-1:0] w_eff_len;
  logic             w_abort_ok;
  logic             w_rco_evt;
  logic             w_count_evt;

  assign w_accept   = (r_state == S_IDLE) && ctrl.cmd_valid;
  // A load-mode RUN makes no sense, so such a command degenerates to load-only.
  assign w_eff_len  = (ctrl.cmd_mode == MODE_LOAD) ? '0 : ctrl.cmd_len;
  assign w_abort_ok = ctrl.abort &&
                      ((r_state == S_LOAD) || (r_state == S_CHECK) || (r_state == S_RUN));

`ifdef CTRL_RCO_ANY_EN
  assign w_rco_evt = |ctrl.ctr_rco;
`else
  assign w_rco_evt = ctrl.ctr_rco[7];
`endif

  // rco lags the counter by one cycle: skip the first RUN cycle, include DRAIN.
  assign w_count_evt = w_rco_evt &&
                       (((r_state == S_RUN) && r_prev_run) || (r_state == S_DRAIN));

  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (ctrl.cmd_preload)    w_next = S_LOAD;
          else if (w_eff_len != 0) w_next = S_RUN;
          else                     w_next = S_DONE;
        end
      end
      S_LOAD:  w_next = ctrl.abort ? S_DRAIN : S_CHECK;
      S_CHECK: begin
        if (ctrl.abort)         w_next = S_DRAIN;
        else if (r_remain != 0) w_next = S_RUN;
        else                    w_next = S_DRAIN;
      end
      S_RUN: begin
        if (ctrl.abort || (r_remain == {{(CNT_W-1){1'b0}}, 1'b1})) w_next = S_DRAIN;
        else                                                      w_next = S_RUN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_mode      <= '0;
      r_D         <= '0;
      r_remain    <= '0;
      r_prev_run  <= 1'b0;
      r_aborted   <= 1'b0;
      r_load_err  <= 1'b0;
      r_rco_count <= '0;
      r_final_Q   <= '0;
    end else begin
      r_prev_run <= (r_state == S_RUN);
      if (w_accept) begin
        r_mode      <= ctrl.cmd_mode;
        r_D         <= ctrl.cmd_D;
        r_remain    <= w_eff_len;
        r_aborted   <= 1'b0;
        r_load_err  <= 1'b0;
        r_rco_count <= '0;
      end else begin
        if (w_abort_ok) r_aborted <= 1'b1;
        if ((r_state == S_CHECK) && ((ctrl.ctr_load != 8'hFF) || (ctrl.ctr_Q != r_D)))
          r_load_err <= 1'b1;
        if (r_state == S_RUN)
          r_remain <= r_remain - {{(CNT_W-1){1'b0}}, 1'b1};
        if (r_state == S_DRAIN)
          r_final_Q <= ctrl.ctr_Q;
        if (w_count_evt && (r_rco_count != {CNT_W{1'b1}}))
          r_rco_count <= r_rco_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    // cmd_ready is qualified with reset so it reads 0 while reset is held.
    ctrl.cmd_ready  = (r_state == S_IDLE) && ctrl_reset;
    ctrl.busy       = (r_state != S_IDLE);
    ctrl.done       = (r_state == S_DONE);
    ctrl.ctr_enable = (r_state == S_LOAD) || (r_state == S_RUN);
    ctrl.ctr_mode   = 2'b00;
    if (r_state == S_LOAD)     ctrl.ctr_mode = MODE_LOAD;
    else if (r_state == S_RUN) ctrl.ctr_mode = r_mode;
    ctrl.ctr_D      = (r_state == S_IDLE) ? 32'd0 : r_D;
    ctrl.aborted    = r_aborted;
    ctrl.load_err   = r_load_err;
    ctrl.rco_count  = r_rco_count;
    ctrl.final_Q    = r_final_Q;
  end

endmodule
